// File: rtl/i2c_cmd_seq.sv
// Command sequencer between CSR logic and an I2C core: buffers command words,
// issues them one at a time, and returns one response word per transaction.
module i2c_cmd_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_data0,
  input  logic [31:0]              cmd_data1,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [1:0]               rsp_err,
  input  logic                     abort,
  output logic [31:0]              core_data0,
  output logic [31:0]              core_data1,
  input  logic [31:0]              core_data2,
  input  logic                     core_busy,
  input  logic                     core_ack_err,
  input  logic                     core_done,
  input  logic                     core_data_ready,
  output logic                     seq_idle,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [AW:0]    FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]    LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
  localparam logic [WW-1:0]  WD_LAST    = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0]  WD_ONE     = WW'(1);

  typedef enum logic [2:0] {IDLE, GO, RUN, RESP, GAP} state_t;

  state_t        state, state_next;
  logic [31:1]   mem_d0 [DEPTH];
  logic [31:0]   mem_d1 [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_next;
  logic          push, pop;
  logic [WW-1:0] wd_cnt;
  logic          wd_fire;
  logic          ack_flag, ack_flag_next;
  logic [31:0]   core_data0_next, core_data1_next, rsp_data_next;
  logic [1:0]    rsp_err_next;
  logic          unused_go_bit;

  // Bit 0 of the incoming control word is always replaced by the go strobe.
  assign unused_go_bit = cmd_data0[0];

  assign push    = cmd_valid && cmd_ready && !abort;
  assign pop     = (state == IDLE) && (fifo_level != '0) && !abort;
  assign wd_fire = (wd_cnt == WD_LAST);

  always_comb begin
    level_next = fifo_level;
    if (abort)
      level_next = '0;
    else if (push && !pop)
      level_next = fifo_level + LVL_ONE;
    else if (pop && !push)
      level_next = fifo_level - LVL_ONE;
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_d0[wr_ptr] <= cmd_data0[31:1];
      mem_d1[wr_ptr] <= cmd_data1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      cmd_ready  <= 1'b1;
    end else begin
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      fifo_level <= level_next;
      cmd_ready  <= (level_next != FULL_LEVEL);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // Abort overrides whatever the per-state logic decided.
  always_comb begin
    state_next      = state;
    core_data0_next = core_data0;
    core_data1_next = core_data1;
    rsp_data_next   = rsp_data;
    rsp_err_next    = rsp_err;
    ack_flag_next   = ack_flag;
    case (state)
      IDLE: begin
        if (pop) begin
          core_data0_next = {mem_d0[rd_ptr], 1'b1};
          core_data1_next = mem_d1[rd_ptr];
          rsp_data_next   = '0;
          rsp_err_next    = 2'b00;
          ack_flag_next   = 1'b0;
          state_next      = GO;
        end
      end
      GO: begin
        if (core_busy) begin
          core_data0_next[0] = 1'b0;
          state_next         = RUN;
        end else if (wd_fire) begin
          core_data0_next[0] = 1'b0;
          rsp_err_next       = 2'b10;
          state_next         = RESP;
        end
      end
      RUN: begin
        if (core_data_ready) rsp_data_next = core_data2;
        if (core_ack_err)    ack_flag_next = 1'b1;
        if (core_done) begin
          rsp_err_next = (ack_flag || core_ack_err) ? 2'b01 : 2'b00;
          state_next   = RESP;
        end else if (wd_fire) begin
          rsp_err_next = 2'b10;
          state_next   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = GAP;
      end
      GAP: begin
        if (!core_busy && !core_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      core_data0_next[0] = 1'b0;
      state_next         = GAP;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      core_data0 <= '0;
      core_data1 <= '0;
      rsp_data   <= '0;
      rsp_err    <= 2'b00;
      rsp_valid  <= 1'b0;
      ack_flag   <= 1'b0;
      seq_idle   <= 1'b1;
    end else begin
      core_data0 <= core_data0_next;
      core_data1 <= core_data1_next;
      rsp_data   <= rsp_data_next;
      rsp_err    <= rsp_err_next;
      rsp_valid  <= (state_next == RESP);
      ack_flag   <= ack_flag_next;
      seq_idle   <= (state_next == IDLE) && (level_next == '0);
    end
  end

  // Watchdog restarts on every state change and sticks at its limit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      wd_cnt <= '0;
    else if (state_next != state)
      wd_cnt <= '0;
    else if (!wd_fire)
      wd_cnt <= wd_cnt + WD_ONE;
  end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Directed bench for i2c_cmd_seq: scoreboard queues hold expected go words and
// responses, filled when commands are pushed and drained as the DUT produces them.
module tb_i2c_cmd_seq;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data0 = '0;
  logic [31:0] cmd_data1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        abort = 1'b0;
  logic [31:0] core_data0;
  logic [31:0] core_data1;
  logic [31:0] core_data2 = '0;
  logic        core_busy = 1'b0;
  logic        core_ack_err = 1'b0;
  logic        core_done = 1'b0;
  logic        core_data_ready = 1'b0;
  logic        seq_idle;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;
  logic [63:0] cmd_q[$];
  logic [33:0] rsp_q[$];

  i2c_cmd_seq #(.DEPTH(4), .TIMEOUT(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data0(cmd_data0), .cmd_data1(cmd_data1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .abort(abort),
    .core_data0(core_data0), .core_data1(core_data1), .core_data2(core_data2),
    .core_busy(core_busy), .core_ack_err(core_ack_err),
    .core_done(core_done), .core_data_ready(core_data_ready),
    .seq_idle(seq_idle), .fifo_level(fifo_level)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push one command; on acceptance record the go word and the response it should yield.
  task automatic applyStimulus(input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] edata, input logic [1:0] eerr,
                               input bit exp_acc);
    bit acc;
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_data0 = d0;
    cmd_data1 = d1;
    acc = cmd_ready;
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    if (acc) begin
      cmd_q.push_back({d0, d1});
      rsp_q.push_back({edata, eerr});
    end
    checkOutput("cmd_accept", 32'(acc), 32'(exp_acc));
  endtask

  task automatic wait_go(output bit seen);
    int n = 0;
    logic [63:0] c;
    while (core_data0[0] !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    seen = (core_data0[0] === 1'b1);
    checkOutput("go_wait", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("go_cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
      if (cmd_q.size() != 0) begin
        c = cmd_q.pop_front();
        checkOutput("go_data0", core_data0, {c[63:33], 1'b1});
        checkOutput("go_data1", core_data1, c[31:0]);
      end
    end
  endtask

  task automatic consume();
    int n = 0;
    logic [33:0] e;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
    if (rsp_q.size() != 0) begin
      e = rsp_q.pop_front();
      checkOutput("rsp_data", rsp_data, e[33:2]);
      checkOutput("rsp_err", 32'(rsp_err), 32'(e[1:0]));
      @(negedge aclk);
      checkOutput("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("rsp_hold_data", rsp_data, e[33:2]);
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_after_ready", 32'(rsp_valid), 32'd0);
  endtask

  // Core model for one transaction; read data is returned twice so the last value must win.
  task automatic serve(input int busy_dly, input bit give_busy, input bit give_done,
                       input bit give_rd, input logic [31:0] rd_val, input bit give_ack);
    bit seen;
    wait_go(seen);
    if (give_busy) begin
      repeat (busy_dly) @(negedge aclk);
      core_busy = 1'b1;
      @(negedge aclk);
      checkOutput("go_drop_on_busy", 32'(core_data0[0]), 32'd0);
      if (give_done) begin
        for (int i = 0; i < 8; i++) begin
          core_data_ready = give_rd && (i == 2 || i == 4);
          core_data2      = (i == 2) ? 32'hDEAD_0000 : rd_val;
          core_ack_err    = give_ack && (i == 3);
          @(negedge aclk);
        end
        core_data_ready = 1'b0;
        core_ack_err    = 1'b0;
        core_done       = 1'b1;
        @(negedge aclk);
        checkOutput("rsp_valid_at_done", 32'(rsp_valid), 32'd1);
        core_done = 1'b0;
        core_busy = 1'b0;
      end
    end
    consume();
    core_busy = 1'b0;
  endtask

  initial begin
    bit seen;
    int n;

    #12;
    checkOutput("rst_core_data0", core_data0, 32'd0);
    checkOutput("rst_core_data1", core_data1, 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_fifo_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_seq_idle", 32'(seq_idle), 32'd1);
    @(negedge aclk);
    aresetn = 1'b1;

    $display("[TB] single write");
    applyStimulus(32'h0000_00A0, 32'h0000_0055, 32'h0, 2'b00, 1'b1);
    serve(3, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    $display("[TB] read with two data_ready pulses");
    applyStimulus(32'h0000_1042, 32'h0000_0000, 32'h0000_003C, 2'b00, 1'b1);
    serve(2, 1'b1, 1'b1, 1'b1, 32'h0000_003C, 1'b0);

    $display("[TB] ack error then next command, go spacing after handshake");
    applyStimulus(32'h0000_0200, 32'h0000_0011, 32'h0, 2'b01, 1'b1);
    applyStimulus(32'h0000_0300, 32'h0000_0022, 32'h0000_0077, 2'b00, 1'b1);
    serve(1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("go_at_r0", 32'(core_data0[0]), 32'd0);
    @(negedge aclk);
    checkOutput("go_at_r1", 32'(core_data0[0]), 32'd0);
    @(negedge aclk);
    checkOutput("go_at_r2", 32'(core_data0[0]), 32'd1);
    serve(1, 1'b1, 1'b1, 1'b1, 32'h0000_0077, 1'b0);

    $display("[TB] timeout in GO");
    applyStimulus(32'h0000_0010, 32'h0000_0000, 32'h0, 2'b10, 1'b1);
    wait_go(seen);
    n = 0;
    while (core_data0[0] === 1'b1 && n < 40) begin
      n++;
      @(negedge aclk);
    end
    checkOutput("go_timeout_cycles", 32'(n), 32'd16);
    checkOutput("go_timeout_rsp_valid", 32'(rsp_valid), 32'd1);
    consume();

    $display("[TB] timeout in RUN");
    applyStimulus(32'h0000_0020, 32'h0000_0001, 32'h0, 2'b10, 1'b1);
    serve(2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("[TB] queue full with GO stalled");
    applyStimulus(32'h0000_0400, 32'h0000_0100, 32'h0, 2'b10, 1'b1);
    for (int i = 1; i <= 4; i++)
      applyStimulus(32'h0000_0400 + 32'(i << 4), 32'h0000_0100 + 32'(i),
                    32'h0000_0100 + 32'(i), 2'b00, 1'b1);
    @(negedge aclk);
    checkOutput("full_fifo_level", 32'(fifo_level), 32'd4);
    checkOutput("full_cmd_ready", 32'(cmd_ready), 32'd0);
    applyStimulus(32'h0000_0500, 32'h0000_0999, 32'h0, 2'b00, 1'b0);
    @(negedge aclk);
    checkOutput("full_level_after_reject", 32'(fifo_level), 32'd4);
    serve(0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++)
      serve(1, 1'b1, 1'b1, 1'b1, 32'h0000_0100 + 32'(i), 1'b0);

    $display("[TB] abort in RUN with two queued");
    applyStimulus(32'h0000_0600, 32'h0000_0AAA, 32'h0, 2'b00, 1'b1);
    wait_go(seen);
    core_busy = 1'b1;
    applyStimulus(32'h0000_0700, 32'h0000_0BBB, 32'h0, 2'b00, 1'b1);
    applyStimulus(32'h0000_0800, 32'h0000_0CCC, 32'h0, 2'b00, 1'b1);
    @(negedge aclk);
    checkOutput("abort_pre_level", 32'(fifo_level), 32'd2);
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_data0 = 32'h0000_0900;
    cmd_data1 = 32'h0000_0DDD;
    @(posedge aclk);
    #1;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    cmd_q.delete();
    rsp_q.delete();
    @(negedge aclk);
    checkOutput("abort_fifo_level", 32'(fifo_level), 32'd0);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_seq_idle_busy", 32'(seq_idle), 32'd0);
    checkOutput("abort_go", 32'(core_data0[0]), 32'd0);
    repeat (3) @(negedge aclk);
    core_busy = 1'b0;
    @(negedge aclk);
    checkOutput("abort_seq_idle", 32'(seq_idle), 32'd1);
    n = 0;
    repeat (10) begin
      @(negedge aclk);
      if (rsp_valid === 1'b1 || core_data0[0] === 1'b1) n++;
    end
    checkOutput("abort_quiet", 32'(n), 32'd0);

    $display("[TB] reset during GO");
    applyStimulus(32'h0000_0A00, 32'h0000_0EEE, 32'h0, 2'b00, 1'b1);
    wait_go(seen);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("mid_rst_core_data0", core_data0, 32'd0);
    checkOutput("mid_rst_core_data1", core_data1, 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("mid_rst_fifo_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mid_rst_seq_idle", 32'(seq_idle), 32'd1);
    cmd_q.delete();
    rsp_q.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge aclk);
      if (rsp_valid === 1'b1 || core_data0[0] === 1'b1) n++;
    end
    checkOutput("post_rst_quiet", 32'(n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
